// File: rtl/cmp_share_pkg.sv
// Shared types and widths for the shared-comparator arbiter.
package cmp_share_pkg;

    // Arbiter control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Operand width of each requester slice
    localparam int unsigned OPND_W = 4;

    // Width of each per-requester grant counter
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/comparator_4bit.sv
// Unsigned 4-bit magnitude comparator; exactly one output is high.
module comparator_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic       gt_o,
    output logic       eq_o,
    output logic       lt_o
);

    // Pure combinational compare
    always_comb begin
        gt_o = (a_i > b_i);
        eq_o = (a_i == b_i);
        lt_o = (a_i < b_i);
    end

endmodule

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter sharing one 4-bit comparator among N_REQ requesters.
// Optional per-requester saturating grant counters: define CMP_SHARE_ARB_STATS_EN.
module cmp_share_arb
    import cmp_share_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*OPND_W-1:0]   a_in,
    input  logic [N_REQ*OPND_W-1:0]   b_in,
    output logic [N_REQ-1:0]          gnt,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_gt,
    output logic                      rsp_eq,
    output logic                      rsp_lt,
    input  logic                      rsp_ready
`ifdef CMP_SHARE_ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]    grant_cnt
`endif
);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [OPND_W-1:0]   op_a_q, op_a_d;
    logic [OPND_W-1:0]   op_b_q, op_b_d;
    logic [ID_W-1:0]     op_id_q, op_id_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                rsp_gt_q, rsp_gt_d;
    logic                rsp_eq_q, rsp_eq_d;
    logic                rsp_lt_q, rsp_lt_d;

    logic                win_found;
    logic [ID_W-1:0]     win_idx;
    logic                grant_fire;
    logic                cmp_gt, cmp_eq, cmp_lt;

    // Round-robin pick: first active request after the last granted index
    always_comb begin
        int unsigned idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_q) + k) % N_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    assign grant_fire = (state_q == IDLE) && win_found;

    comparator_4bit u_cmp (
        .a_i  (op_a_q),
        .b_i  (op_b_q),
        .gt_o (cmp_gt),
        .eq_o (cmp_eq),
        .lt_o (cmp_lt)
    );

    // Next-state and datapath updates for the IDLE -> CMP -> RESP sequence
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        gnt_d       = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_gt_d    = rsp_gt_q;
        rsp_eq_d    = rsp_eq_q;
        rsp_lt_d    = rsp_lt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d        = CMP;
                    last_d         = win_idx;
                    op_id_d        = win_idx;
                    op_a_d         = a_in[int'(win_idx)*OPND_W +: OPND_W];
                    op_b_d         = b_in[int'(win_idx)*OPND_W +: OPND_W];
                    gnt_d[win_idx] = 1'b1;
                end
            end
            CMP: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = op_id_q;
                rsp_gt_d    = cmp_gt;
                rsp_eq_d    = cmp_eq;
                rsp_lt_d    = cmp_lt;
                state_d     = RESP;
            end
            RESP: begin
                // Response fields stay frozen; only valid drops on handshake
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; last_q starts at N_REQ-1 so 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= ID_W'(N_REQ - 1);
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_gt_q    <= 1'b0;
            rsp_eq_q    <= 1'b0;
            rsp_lt_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_gt_q    <= rsp_gt_d;
            rsp_eq_q    <= rsp_eq_d;
            rsp_lt_q    <= rsp_lt_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_gt    = rsp_gt_q;
    assign rsp_eq    = rsp_eq_q;
    assign rsp_lt    = rsp_lt_q;

`ifdef CMP_SHARE_ARB_STATS_EN
    logic [N_REQ*CNT_W-1:0] cnt_q;

    // Saturating grant counters, bumped in step with each gnt pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (grant_fire && (int'(win_idx) == i) &&
                    (cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    cnt_q[i*CNT_W +: CNT_W] <= cnt_q[i*CNT_W +: CNT_W] + 1'b1;
                end
            end
        end
    end

    assign grant_cnt = cnt_q;
`else
    logic unused_grant_fire;
    assign unused_grant_fire = grant_fire;
`endif

endmodule

// File: tb/tb_cmp_share_arb.sv
// Directed self-checking bench for cmp_share_arb.
// The grant counter test runs only when CMP_SHARE_ARB_STATS_EN is defined.
module tb_cmp_share_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic        rsp_gt;
    logic        rsp_eq;
    logic        rsp_lt;
    logic        rsp_ready;
`ifdef CMP_SHARE_ARB_STATS_EN
    logic [31:0] grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    cmp_share_arb #(
        .N_REQ (4),
        .ID_W  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_gt    (rsp_gt),
        .rsp_eq    (rsp_eq),
        .rsp_lt    (rsp_lt),
        .rsp_ready (rsp_ready)
`ifdef CMP_SHARE_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_ids [5];
        exp_ids = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        req = '0; a_in = '0; b_in = '0; rsp_ready = 1'b1; rst = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_gnt", 32'(gnt), 32'h0);
        check_eq("rst_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_id", 32'(rsp_id), 32'h0);
        check_eq("rst_flags", {29'd0, rsp_gt, rsp_eq, rsp_lt}, 32'h0);

        // Single request: 9 > 6
        req = 4'b0001; a_in[3:0] = 4'b1001; b_in[3:0] = 4'b0110;
        tick();
        check_eq("single_gnt", 32'(gnt), 32'h1);
        check_eq("single_novalid", 32'(rsp_valid), 32'h0);
        req = '0;
        tick();
        check_eq("single_gnt_clr", 32'(gnt), 32'h0);
        check_eq("single_valid", 32'(rsp_valid), 32'h1);
        check_eq("single_id", 32'(rsp_id), 32'h0);
        check_eq("single_flags", {29'd0, rsp_gt, rsp_eq, rsp_lt}, 32'h4);
        tick();
        check_eq("single_done", 32'(rsp_valid), 32'h0);

        // All requesters: order 0,1,2,3,0 at 3-cycle spacing
        do_reset();
        a_in = 16'h3210; b_in = 16'h1111;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check_eq($sformatf("rr_gnt%0d", g), 32'(gnt), 32'(4'b0001 << exp_ids[g]));
            tick();
            check_eq($sformatf("rr_gap%0d", g), 32'(gnt), 32'h0);
            check_eq($sformatf("rr_id%0d", g), 32'(rsp_id), 32'(exp_ids[g]));
            tick();
        end
        req = '0;
        tick(); tick(); tick();
        // last grant is now 0

        // Backpressure on requester 1: 4 < 8
        a_in = 16'h0040; b_in = 16'h0080; rsp_ready = 1'b0;
        req = 4'b0010;
        tick();
        check_eq("bp_gnt", 32'(gnt), 32'h2);
        req = 4'b1101;
        tick();
        check_eq("bp_valid", 32'(rsp_valid), 32'h1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq($sformatf("bp_hold_valid%0d", c), 32'(rsp_valid), 32'h1);
            check_eq($sformatf("bp_hold_flags%0d", c), {29'd0, rsp_gt, rsp_eq, rsp_lt}, 32'h1);
            check_eq($sformatf("bp_hold_id%0d", c), 32'(rsp_id), 32'h1);
            check_eq($sformatf("bp_no_gnt%0d", c), 32'(gnt), 32'h0);
        end
        rsp_ready = 1'b1;
        tick();
        check_eq("bp_release", 32'(rsp_valid), 32'h0);
        check_eq("bp_release_gnt", 32'(gnt), 32'h0);
        tick();
        check_eq("bp_next_gnt", 32'(gnt), 32'h4);
        req = '0;
        tick(); tick();
        // last grant is now 2

        // Equal operands on requester 2
        a_in = 16'h0F00; b_in = 16'h0F00;
        req = 4'b0100;
        tick();
        check_eq("eq_gnt", 32'(gnt), 32'h4);
        req = '0;
        tick();
        check_eq("eq_valid", 32'(rsp_valid), 32'h1);
        check_eq("eq_flags", {29'd0, rsp_gt, rsp_eq, rsp_lt}, 32'h2);
        check_eq("eq_id", 32'(rsp_id), 32'h2);
        tick();

        // Reset during CMP drops the compare and restores priority to 0
        a_in = 16'h5000; b_in = 16'h1000;
        req = 4'b1000;
        tick();
        check_eq("rstmid_gnt", 32'(gnt), 32'h8);
        req = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rstmid_gnt0", 32'(gnt), 32'h0);
        check_eq("rstmid_valid0", 32'(rsp_valid), 32'h0);
        check_eq("rstmid_id0", 32'(rsp_id), 32'h0);
        check_eq("rstmid_flags0", {29'd0, rsp_gt, rsp_eq, rsp_lt}, 32'h0);
        tick();
        check_eq("rstmid_nostale", 32'(rsp_valid), 32'h0);
        req = 4'b1111;
        tick();
        check_eq("rstmid_next_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick(); tick(); tick();

`ifdef CMP_SHARE_ARB_STATS_EN
        // 260 grants to requester 1 saturate its counter at 255
        do_reset();
        check_eq("cnt_rst", grant_cnt, 32'h0);
        req = 4'b0010;
        for (int g = 0; g < 260; g++) begin
            tick(); tick(); tick();
        end
        req = '0;
        tick(); tick(); tick();
        check_eq("cnt_sat", 32'(grant_cnt[15:8]), 32'd255);
        check_eq("cnt_others", {grant_cnt[31:16], 8'd0, grant_cnt[7:0]}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_share_arb.md
CMP_SHARE_ARB -- requirements
Module: cmp_share_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the comparator; legal values 2..4.
REQ-002 Parameter ID_W, default 2, requester index width; SHALL equal clog2(N_REQ), minimum 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req  input  N_REQ  per-requester compare request.
REQ-006 a_in  input  N_REQ*4  operand A; slice i belongs to requester i.
REQ-007 b_in  input  N_REQ*4  operand B; slice i belongs to requester i.
REQ-008 gnt  output  N_REQ  one-hot acceptance pulse, registered.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_id  output  ID_W  index of the requester that owns the result.
REQ-011 rsp_gt, rsp_eq, rsp_lt  output  1 each  A>B, A==B, A<B for the granted operands.
REQ-012 rsp_ready  input  1  consumer accepts the result.

Function
REQ-013 FSM states: IDLE, CMP, RESP.
REQ-014 IDLE: if req is nonzero at an edge, latch the winner's A/B slices and index into operand registers, set gnt[winner]=1 for exactly one cycle, then go to CMP. If req is zero, stay in IDLE.
REQ-015 Arbitration: round-robin. Search starts at last_grant+1 mod N_REQ. last_grant updates only when a grant is issued.
REQ-016 CMP: the single comparator evaluates the operand registers. At the next edge, capture gt/eq/lt and the index into response registers, set rsp_valid=1, clear gnt, go to RESP.
REQ-017 RESP: hold rsp_valid and all rsp_* fields stable until rsp_ready=1 at an edge. Then clear rsp_valid and go to IDLE.
REQ-018 Latency: req sampled at edge N gives gnt high in cycle N..N+1 and rsp_valid high from edge N+1. The minimum period between two grants is 3 cycles.
REQ-019 Exactly one of rsp_gt/rsp_eq/rsp_lt SHALL be 1 whenever rsp_valid=1.
REQ-020 req and operand changes in CMP or RESP are ignored. A requester keeps req and its operands stable until it sees its gnt, then drops req.
REQ-021 rsp_ready while rsp_valid=0 has no effect.
REQ-022 Comparison is unsigned on 4 bits. There is no overflow case.

Reset
REQ-023 While rst=1 at an edge: state=IDLE, gnt=0, rsp_valid=0, rsp_id=0, rsp_gt/eq/lt=0, operand registers=0, last_grant=N_REQ-1 (requester 0 has first priority).
REQ-024 Reset in CMP or RESP discards the in-flight compare. No rsp_valid follows for it.

Configuration
REQ-025 Macro CMP_SHARE_ARB_STATS_EN.
- Defined: adds output grant_cnt (N_REQ*8), one 8-bit per-requester grant counter that increments on each gnt pulse. It saturates at 255 and resets to 0.
- Undefined: the port and counters are absent. All other behaviour is identical.

Structure
REQ-026 Package cmp_share_pkg holds:
- the state enum typedef (IDLE, CMP, RESP);
- the operand width constant (4);
- the counter width constant (8).
REQ-027 Exactly one instance of the existing comparator_4bit sub-module is driven from the operand registers. No other compare logic is allowed.

Verification
REQ-028 Single request: req=0001, A0=1001, B0=0110. Expect gnt=0001 one cycle, then rsp_valid=1, rsp_id=0, rsp_gt=1.
REQ-029 All requesters at once, rsp_ready=1: req=1111 held and re-raised after each gnt. Expect grant order 0,1,2,3,0 at 3-cycle spacing.
REQ-030 Backpressure: rsp_ready=0 for 5 cycles with A=0100, B=1000. Expect rsp_lt=1 and rsp_valid held stable throughout, and no new gnt until rsp_ready=1.
REQ-031 Equal operands A=1111, B=1111 on requester 2. Expect rsp_eq=1, rsp_gt=0, rsp_lt=0, rsp_id=2.
REQ-032 Reset mid-operation: assert rst during CMP. Expect all outputs 0 the next cycle, no stale rsp_valid, and the next grant goes to requester 0.
REQ-033 With CMP_SHARE_ARB_STATS_EN defined: 260 grants to requester 1. Expect grant_cnt[15:8]=255 and all other counters 0.
